// File: rtl/alu_issue_if.sv
// Bundle of the upstream request, ALU issue/return and downstream result signals of alu_issue.
// A transfer on any valid/ready pair happens on the rising edge where both are 1.
// Valid must then hold its data stable until that edge, and ready may change freely.
// Exception: alu_action_valid is a single-cycle issue pulse, and alu_result_valid is a strobe.
interface alu_issue_if #(
    parameter int ACTION_LEN = 64,
    parameter int DATA_WIDTH = 32
);
    logic [ACTION_LEN-1:0] s_action;
    logic [DATA_WIDTH-1:0] s_op1;
    logic [DATA_WIDTH-1:0] s_op2;
    logic [DATA_WIDTH-1:0] s_op3;
    logic [DATA_WIDTH-1:0] s_op4;
    logic                  s_valid;
    logic                  s_ready;

    logic [ACTION_LEN-1:0] alu_action;
    logic                  alu_action_valid;
    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_op2;
    logic [DATA_WIDTH-1:0] alu_op3;
    logic [DATA_WIDTH-1:0] alu_op4;
    logic                  alu_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_result_valid;
    logic                  alu_ready_in;

    logic [DATA_WIDTH-1:0] m_result;
    logic [7:0]            m_opcode;
    logic                  m_err;
    logic                  m_valid;
    logic                  m_ready;
    logic [15:0]           result_cnt;

    modport slave (
        input  s_action, s_op1, s_op2, s_op3, s_op4, s_valid,
        input  alu_ready, alu_result, alu_result_valid, m_ready,
        output s_ready, alu_action, alu_action_valid,
        output alu_op1, alu_op2, alu_op3, alu_op4, alu_ready_in,
        output m_result, m_opcode, m_err, m_valid, result_cnt
    );

    modport master (
        output s_action, s_op1, s_op2, s_op3, s_op4, s_valid,
        output alu_ready, alu_result, alu_result_valid, m_ready,
        input  s_ready, alu_action, alu_action_valid,
        input  alu_op1, alu_op2, alu_op3, alu_op4, alu_ready_in,
        input  m_result, m_opcode, m_err, m_valid, result_cnt
    );
endinterface

// File: rtl/alu_issue.sv
// Single-outstanding ALU issue stage: accept action+operands, issue to ALU, wait for result, hand downstream.
// Optional result watchdog built only when ALU_ISSUE_TIMEOUT_EN is defined.
module alu_issue #(
    parameter int ACTION_LEN     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ACTION_LEN-1:0] hold_action;
    logic [DATA_WIDTH-1:0] hold_op1, hold_op2, hold_op3, hold_op4;
    logic [7:0]            hold_opcode;
    logic [DATA_WIDTH-1:0] result_q;
    logic [7:0]            opcode_q;
    logic [15:0]           cnt_q;
    logic                  accept, issue, take_result, take_timeout, out_fire;
    logic                  wd_expired;

    assign hold_opcode = hold_action[ACTION_LEN-1 -: 8];

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        issue        = 1'b0;
        take_result  = 1'b0;
        take_timeout = 1'b0;
        out_fire     = 1'b0;
        case (state_q)
            IDLE: if (bus.s_valid) begin
                accept  = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (bus.alu_ready) begin
                issue   = 1'b1;
                state_d = WAIT;
            end
            // A result arriving on the limit cycle beats the watchdog.
            WAIT: if (bus.alu_result_valid) begin
                take_result = 1'b1;
                state_d     = OUT;
            end else if (wd_expired) begin
                take_timeout = 1'b1;
                state_d      = OUT;
            end
            OUT: if (bus.m_ready) begin
                out_fire = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_action <= '0;
            hold_op1    <= '0;
            hold_op2    <= '0;
            hold_op3    <= '0;
            hold_op4    <= '0;
        end else if (accept) begin
            hold_action <= bus.s_action;
            hold_op1    <= bus.s_op1;
            hold_op2    <= bus.s_op2;
            hold_op3    <= bus.s_op3;
            hold_op4    <= bus.s_op4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            opcode_q <= '0;
        end else if (take_result) begin
            result_q <= bus.alu_result;
            opcode_q <= hold_opcode;
        end else if (take_timeout) begin
            result_q <= '0;
            opcode_q <= hold_opcode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_q <= '0;
        else if (out_fire) cnt_q <= cnt_q + 16'd1;
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           wd_q <= '0;
        else if (issue)                                    wd_q <= '0;
        else if (state_q == WAIT && !bus.alu_result_valid) wd_q <= wd_q + 16'd1;
    end

    assign wd_expired = (wd_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               err_q <= 1'b0;
        else if (take_result)  err_q <= 1'b0;
        else if (take_timeout) err_q <= 1'b1;
    end

    assign bus.m_err = err_q;
`else
    // No watchdog: the limit is always at least 1, so this never fires and WAIT is unbounded.
    assign wd_expired = (TIMEOUT_CYCLES == 0);
    assign bus.m_err  = 1'b0;
`endif

    assign bus.s_ready          = (state_q == IDLE);
    assign bus.alu_action_valid = issue;
    assign bus.alu_ready_in     = (state_q == WAIT);
    assign bus.m_valid          = (state_q == OUT);
    assign bus.alu_action       = hold_action;
    assign bus.alu_op1          = hold_op1;
    assign bus.alu_op2          = hold_op2;
    assign bus.alu_op3          = hold_op3;
    assign bus.alu_op4          = hold_op4;
    assign bus.m_result         = result_q;
    assign bus.m_opcode         = opcode_q;
    assign bus.result_cnt       = cnt_q;
    assign dbg_state            = state_q;
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter ACTION_LEN, default 64, width of the action word.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of each operand and result.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles, range 1..65535.
REQ-004 SHALL have ports:
clk  in  1  single clock; all logic rising-edge.
rst  in  1  asynchronous, active-high reset.
s_action  in  ACTION_LEN  action from sub-action stage; opcode = s_action[63:56].
s_op1 / s_op2 / s_op3 / s_op4  in  DATA_WIDTH each  operands.
s_valid  in  1  upstream request valid.
s_ready  out  1  upstream request accepted when s_valid && s_ready.
alu_action  out  ACTION_LEN  action to ALU.
alu_action_valid  out  1  one-cycle issue pulse to ALU.
alu_op1 / alu_op2 / alu_op3 / alu_op4  out  DATA_WIDTH each  operands to ALU.
alu_ready  in  1  ALU idle/ready indication.
alu_result  in  DATA_WIDTH  ALU result, valid only with alu_result_valid.
alu_result_valid  in  1  ALU result strobe.
alu_ready_in  out  1  result-accept indication driven to ALU.
m_result  out  DATA_WIDTH  result toward PHV build.
m_opcode  out  8  opcode of the completed action.
m_err  out  1  result is a watchdog abort.
m_valid  out  1  downstream valid.
m_ready  in  1  downstream accepted when m_valid && m_ready.
result_cnt  out  16  completed-action counter.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, OUT.
REQ-006 s_ready SHALL equal 1 only in IDLE.
REQ-007 On an IDLE handshake: latch action and all four operands into holding registers; go to ISSUE.
REQ-008 alu_action and alu_op1..4 SHALL be driven from the holding registers and SHALL stay stable from ISSUE through OUT.
REQ-009 In ISSUE with alu_ready=1: assert alu_action_valid for exactly that cycle; go to WAIT.
REQ-010 In ISSUE with alu_ready=0: keep alu_action_valid=0; stay in ISSUE.
REQ-011 alu_ready_in SHALL be 1 in WAIT and 0 in every other state.
REQ-012 In WAIT with alu_result_valid=1: capture alu_result into m_result, opcode into m_opcode, m_err=0; go to OUT.
REQ-013 alu_result_valid outside WAIT SHALL be ignored; no state or output change.
REQ-014 In OUT: m_valid=1. On m_ready=1 go to IDLE and deassert m_valid the next cycle; otherwise hold m_result, m_opcode, m_err.
REQ-015 result_cnt SHALL increment by 1 on each OUT handshake and wrap 0xFFFF -> 0x0000.
REQ-016 Minimum latency: s handshake at cycle N -> alu_action_valid at N+1 -> m_valid at the cycle after alu_result_valid.
REQ-017 The block SHALL allow at most one action outstanding.

Reset
REQ-018 While rst=1 (asynchronous): state=IDLE; s_ready=1; alu_action_valid=0; alu_ready_in=0; m_valid=0; m_err=0; m_result=0; m_opcode=0; result_cnt=0; holding registers=0; watchdog=0.
REQ-019 Reset asserted mid-operation SHALL abandon the in-flight action with no downstream output; first cycle after release is IDLE.

Configuration
REQ-020 Macro ALU_ISSUE_TIMEOUT_EN defined: a 16-bit watchdog clears on WAIT entry and increments each WAIT cycle without alu_result_valid.
REQ-021 On reaching TIMEOUT_CYCLES: go to OUT with m_result=0, m_err=1, m_opcode=held opcode.
REQ-022 If alu_result_valid arrives in the same cycle the limit is reached, the result SHALL win (m_err=0).
REQ-023 Macro undefined: no watchdog logic is built; WAIT lasts indefinitely; m_err is tied 0.

Verification
REQ-024 Add: s_action[63:56]=0x01, op1=5, op2=7, alu_ready=1, ALU returns 12 two cycles after issue -> one alu_action_valid pulse, m_result=12, m_opcode=0x01, m_err=0, result_cnt=1.
REQ-025 ALU busy: alu_ready=0 for 4 cycles after accept -> alu_action_valid stays 0 for 4 cycles, then pulses once; operands unchanged throughout.
REQ-026 Backpressure: m_ready=0 for 3 cycles in OUT -> m_valid and m_result=0x1234 held; s_ready=0; a stray alu_result_valid is ignored.
REQ-027 Counter wrap: preload via 65535 completions, one more -> result_cnt=0x0000.
REQ-028 Timeout (macro defined, TIMEOUT_CYCLES=8): no ALU result -> m_valid after 8 WAIT cycles with m_err=1, m_result=0; result at cycle 8 -> m_err=0.
REQ-029 Reset during WAIT -> m_valid never asserts, s_ready=1 after release, result_cnt=0.
